pc_fetch_unit: RTL and testbench

//  IF-stage program counter: holds current PC, consumes PC+1 from incrementer, drives instruction memory.
//  Req/ready handshake to imem; loads IF/ID pipeline register (pc, pc+1, instr, valid).

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/counter.sv | 12 +
 rtl/pc_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
// Fetch FSM encoding and fetch-stage defaults.
package pipeline_pkg;

  typedef enum logic [2:0] {
    FS_BOOT  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WAIT  = 3'd2,
    FS_HOLD  = 3'd3,
    FS_DRAIN = 3'd4
  } fetch_state_e;

  localparam int unsigned INSTR_W_DEF  = 32;
  localparam int unsigned RESET_PC_DEF = 0;

endpackage

// File: rtl/counter.sv
// Incrementer used by the fetch unit for pc+1.
// Wraps modulo 2^width with no carry out.
module counter #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] val_i,
  output logic [width-1:0] inc_o
);

  assign inc_o = val_i + width'(1);

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: PC register, imem req/ready handshake,
// one-entry skid for stalls, and the IF/ID register.
module pc_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [WIDTH-1:0]   redirect_pc_i,
  output logic               imem_req_o,
  output logic [WIDTH-1:0]   imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [WIDTH-1:0]   if_pc_o,
  output logic [WIDTH-1:0]   if_pc_next_o,
  output logic [INSTR_W-1:0] if_instr_o
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);

  fetch_state_e state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d, pc_inc;
  logic [WIDTH-1:0]   drain_addr_q, drain_addr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [WIDTH-1:0]   skid_pcn_q, skid_pcn_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               ifv_q, ifv_d;
  logic [WIDTH-1:0]   ifpc_q, ifpc_d;
  logic [WIDTH-1:0]   ifpcn_q, ifpcn_d;
  logic [INSTR_W-1:0] ifinstr_q, ifinstr_d;
  logic               req;

  counter #(.width(WIDTH)) u_inc (
    .val_i (pc_q),
    .inc_o (pc_inc)
  );

  assign req = (state_q == FS_REQ)
            || (state_q == FS_WAIT)
            || (state_q == FS_DRAIN);

  // The stale request after a redirect keeps its own address.
  assign imem_req_o  = req;
  assign imem_addr_o = !req ? '0
                     : (state_q == FS_DRAIN) ? drain_addr_q
                     : pc_q;

  assign if_valid_o   = ifv_q;
  assign if_pc_o      = ifpc_q;
  assign if_pc_next_o = ifpcn_q;
  assign if_instr_o   = ifinstr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_pcn_d   = skid_pcn_q;
    skid_instr_d = skid_instr_q;
    ifv_d        = stall_i ? ifv_q : 1'b0;
    ifpc_d       = ifpc_q;
    ifpcn_d      = ifpcn_q;
    ifinstr_d    = ifinstr_q;

    if (redirect_i) begin
      pc_d         = redirect_pc_i;
      ifv_d        = 1'b0;
      skid_valid_d = 1'b0;
      unique case (state_q)
        FS_REQ, FS_WAIT, FS_DRAIN: begin
          if (imem_ready_i) begin
            state_d = FS_REQ;
          end else begin
            state_d = FS_DRAIN;
            if (state_q != FS_DRAIN) drain_addr_d = pc_q;
          end
        end
        default: state_d = FS_REQ;
      endcase
    end else begin
      unique case (state_q)
        FS_BOOT: state_d = FS_REQ;
        FS_REQ, FS_WAIT: begin
          if (imem_ready_i) begin
            pc_d = pc_inc;
            if (stall_i) begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_pcn_d   = pc_inc;
              skid_instr_d = imem_rdata_i;
              state_d      = FS_HOLD;
            end else begin
              ifv_d     = 1'b1;
              ifpc_d    = pc_q;
              ifpcn_d   = pc_inc;
              ifinstr_d = imem_rdata_i;
              state_d   = FS_REQ;
            end
          end else begin
            state_d = FS_WAIT;
          end
        end
        FS_HOLD: begin
          if (!stall_i) begin
            ifv_d        = skid_valid_q;
            ifpc_d       = skid_pc_q;
            ifpcn_d      = skid_pcn_q;
            ifinstr_d    = skid_instr_q;
            skid_valid_d = 1'b0;
            state_d      = FS_REQ;
          end
        end
        FS_DRAIN: if (imem_ready_i) state_d = FS_REQ;
        default: state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_BOOT;
      pc_q         <= RST_PC;
      drain_addr_q <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_pcn_q   <= '0;
      skid_instr_q <= '0;
      ifv_q        <= 1'b0;
      ifpc_q       <= '0;
      ifpcn_q      <= '0;
      ifinstr_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_pcn_q   <= skid_pcn_d;
      skid_instr_q <= skid_instr_d;
      ifv_q        <= ifv_d;
      ifpc_q       <= ifpc_d;
      ifpcn_q      <= ifpcn_d;
      ifinstr_q    <= ifinstr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: 32-bit instance with a
// fetch scoreboard, plus a 4-bit instance for wrap/reset.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst_n, stall, redir, ready;
  logic [31:0] rpc, addr, rdata, ifpc, ifpcn, ifinstr;
  logic        req, ifv;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign rdata = instr_of(addr);

  pc_fetch_unit u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ready_i  (ready),
    .imem_rdata_i  (rdata),
    .if_valid_o    (ifv),
    .if_pc_o       (ifpc),
    .if_pc_next_o  (ifpcn),
    .if_instr_o    (ifinstr)
  );

  logic       rst4_n, stall4, redir4, ready4;
  logic [3:0] rpc4, addr4, ifpc4, ifpcn4;
  logic [7:0] rdata4, ifinstr4;
  logic       req4, ifv4;

  assign rdata4 = {4'hA, addr4};

  pc_fetch_unit #(.WIDTH(4), .INSTR_W(8), .RESET_PC(14)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst4_n),
    .stall_i       (stall4),
    .redirect_i    (redir4),
    .redirect_pc_i (rpc4),
    .imem_req_o    (req4),
    .imem_addr_o   (addr4),
    .imem_ready_i  (ready4),
    .imem_rdata_i  (rdata4),
    .if_valid_o    (ifv4),
    .if_pc_o       (ifpc4),
    .if_pc_next_o  (ifpcn4),
    .if_instr_o    (ifinstr4)
  );

  // Transaction model: expected fetch address and accepted PCs.
  logic [31:0] q[$];
  logic [31:0] exp_pc;
  logic [31:0] drain_addr;
  bit          draining;

  task automatic tick();
    logic [31:0] e;
    if (rst_n) begin
      if (redir) begin
        q.delete();
      end else if (ifv && !stall) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: valid pc=%0h, need no valid entry", ifpc);
        end else begin
          e = q.pop_front();
          if (ifpc !== e || ifpcn !== e + 32'd1 || ifinstr !== instr_of(e)) begin
            errors++;
            $display("FAIL sb_entry: pc=%0h next=%0h instr=%0h, need %0h %0h %0h",
                     ifpc, ifpcn, ifinstr, e, e + 32'd1, instr_of(e));
          end
        end
      end
      if (req) begin
        checks++;
        e = draining ? drain_addr : exp_pc;
        if (addr !== e) begin
          errors++;
          $display("FAIL sb_addr: addr=%0h, need %0h", addr, e);
        end
      end
      if (redir) begin
        if (req && !ready) begin
          if (!draining) drain_addr = exp_pc;
          draining = 1'b1;
        end else begin
          draining = 1'b0;
        end
        exp_pc = rpc;
      end else if (req && ready) begin
        if (draining) begin
          draining = 1'b0;
        end else begin
          q.push_back(exp_pc);
          exp_pc = exp_pc + 32'd1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redir = 1'b0;
    ready = 1'b0;
    rpc   = '0;
    q.delete();
    exp_pc   = '0;
    draining = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req !== 1'b0 || addr !== 32'd0 || ifv !== 1'b0 ||
        ifpc !== 32'd0 || ifpcn !== 32'd0 || ifinstr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outs: req=%0b addr=%0h v=%0b pc=%0h nx=%0h in=%0h, need all 0",
               req, addr, ifv, ifpc, ifpcn, ifinstr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL boot_req: req=%0b, need 0", req);
    end
  endtask

  task automatic test_stream();
    ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (req !== 1'b1 || addr !== 32'(k - 1)) begin
        errors++;
        $display("FAIL stream_addr%0d: req=%0b addr=%0h, need 1 %0h", k, req, addr, k - 1);
      end
      checks++;
      if (k == 1 ? (ifv !== 1'b0) : (ifv !== 1'b1 || ifpc !== 32'(k - 2))) begin
        errors++;
        $display("FAIL stream_if%0d: v=%0b pc=%0h", k, ifv, ifpc);
      end
    end
  endtask

  task automatic test_wait();
    int n = 0;
    while (!(req === 1'b1 && addr === 32'd5) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!(req === 1'b1 && addr === 32'd5)) begin
      errors++;
      $display("FAIL wait_reach: addr=%0h, need 5 within 20 cycles", addr);
    end
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (req !== 1'b1 || addr !== 32'd5 || ifv !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d: req=%0b addr=%0h v=%0b, need 1 5 0", k, req, addr, ifv);
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (ifv !== 1'b1 || ifpc !== 32'd5 || ifinstr !== instr_of(32'd5) || addr !== 32'd6) begin
      errors++;
      $display("FAIL wait_done: v=%0b pc=%0h in=%0h addr=%0h", ifv, ifpc, ifinstr, addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (req !== 1'b0 || ifv !== 1'b1 || ifpc !== 32'd5) begin
        errors++;
        $display("FAIL stall_frz%0d: req=%0b v=%0b pc=%0h, need 0 1 5", k, req, ifv, ifpc);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (req !== 1'b1 || addr !== 32'd7 || ifv !== 1'b1 ||
        ifpc !== 32'd6 || ifinstr !== instr_of(32'd6)) begin
      errors++;
      $display("FAIL stall_skid: req=%0b addr=%0h v=%0b pc=%0h", req, addr, ifv, ifpc);
    end
    tick();
    checks++;
    if (addr !== 32'd8 || ifpc !== 32'd7) begin
      errors++;
      $display("FAIL stall_resume: addr=%0h pc=%0h, need 8 7", addr, ifpc);
    end
  endtask

  task automatic test_redirect_wait();
    ready = 1'b0;
    tick();
    checks++;
    if (req !== 1'b1 || addr !== 32'd8 || ifv !== 1'b0) begin
      errors++;
      $display("FAIL rdw_wait: req=%0b addr=%0h v=%0b", req, addr, ifv);
    end
    redir = 1'b1;
    rpc   = 32'h40;
    tick();
    redir = 1'b0;
    checks++;
    if (req !== 1'b1 || addr !== 32'd8 || ifv !== 1'b0) begin
      errors++;
      $display("FAIL rdw_drain: req=%0b addr=%0h v=%0b, need 1 8 0", req, addr, ifv);
    end
    tick();
    ready = 1'b1;
    tick();
    checks++;
    if (req !== 1'b1 || addr !== 32'h40 || ifv !== 1'b0) begin
      errors++;
      $display("FAIL rdw_target: req=%0b addr=%0h v=%0b, need 1 40 0", req, addr, ifv);
    end
    tick();
    checks++;
    if (addr !== 32'h41 || ifv !== 1'b1 || ifpc !== 32'h40) begin
      errors++;
      $display("FAIL rdw_first: addr=%0h v=%0b pc=%0h", addr, ifv, ifpc);
    end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    tick();
    checks++;
    if (req !== 1'b0 || ifv !== 1'b1 || ifpc !== 32'h40) begin
      errors++;
      $display("FAIL rdh_hold: req=%0b v=%0b pc=%0h", req, ifv, ifpc);
    end
    redir = 1'b1;
    rpc   = 32'h80;
    tick();
    redir = 1'b0;
    stall = 1'b0;
    checks++;
    if (req !== 1'b1 || addr !== 32'h80 || ifv !== 1'b0) begin
      errors++;
      $display("FAIL rdh_target: req=%0b addr=%0h v=%0b, need 1 80 0", req, addr, ifv);
    end
    tick();
    checks++;
    if (addr !== 32'h81 || ifv !== 1'b1 || ifpc !== 32'h80) begin
      errors++;
      $display("FAIL rdh_first: addr=%0h v=%0b pc=%0h", addr, ifv, ifpc);
    end
  endtask

  task automatic test_back_to_back();
    redir = 1'b1;
    rpc   = 32'hFFFF_FFFF;
    tick();
    redir = 1'b0;
    checks++;
    if (req !== 1'b1 || addr !== 32'hFFFF_FFFF || ifv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_target: req=%0b addr=%0h v=%0b", req, addr, ifv);
    end
    tick();
    checks++;
    if (addr !== 32'd0 || ifpc !== 32'hFFFF_FFFF || ifpcn !== 32'd0) begin
      errors++;
      $display("FAIL b2b_wrap: addr=%0h pc=%0h nx=%0h", addr, ifpc, ifpcn);
    end
    repeat (3) tick();
  endtask

  task automatic test_wrap_reset();
    logic [3:0] e;
    ready4 = 1'b1;
    rst4_n = 1'b1;
    #1;
    checks++;
    if (req4 !== 1'b0) begin
      errors++;
      $display("FAIL w4_boot: req=%0b, need 0", req4);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = 4'(14 + k);
      checks++;
      if (req4 !== 1'b1 || addr4 !== e) begin
        errors++;
        $display("FAIL w4_addr%0d: req=%0b addr=%0h, need 1 %0h", k, req4, addr4, e);
      end
      if (k >= 1) begin
        e = 4'(13 + k);
        checks++;
        if (ifv4 !== 1'b1 || ifpc4 !== e || ifpcn4 !== e + 4'd1 || ifinstr4 !== {4'hA, e}) begin
          errors++;
          $display("FAIL w4_if%0d: v=%0b pc=%0h nx=%0h in=%0h", k, ifv4, ifpc4, ifpcn4, ifinstr4);
        end
      end
    end
    ready4 = 1'b0;
    @(negedge clk);
    checks++;
    if (req4 !== 1'b1 || addr4 !== 4'd1 || ifv4 !== 1'b0) begin
      errors++;
      $display("FAIL w4_wait: req=%0b addr=%0h v=%0b", req4, addr4, ifv4);
    end
    #2 rst4_n = 1'b0;
    #1;
    checks++;
    if (req4 !== 1'b0 || addr4 !== 4'd0 || ifv4 !== 1'b0 ||
        ifpc4 !== 4'd0 || ifpcn4 !== 4'd0 || ifinstr4 !== 8'd0) begin
      errors++;
      $display("FAIL w4_arst: req=%0b addr=%0h v=%0b pc=%0h nx=%0h in=%0h",
               req4, addr4, ifv4, ifpc4, ifpcn4, ifinstr4);
    end
    @(negedge clk);
    rst4_n = 1'b1;
    ready4 = 1'b1;
    @(negedge clk);
    checks++;
    if (req4 !== 1'b1 || addr4 !== 4'd14) begin
      errors++;
      $display("FAIL w4_restart: req=%0b addr=%0h, need 1 e", req4, addr4);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    stall4 = 1'b0;
    redir4 = 1'b0;
    ready4 = 1'b0;
    rpc4   = '0;
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_back_to_back();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
